// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: parametrised pipeline stage register with a 2-entry skid
// buffer and full valid/ready handshakes on both sides.
//
// Handshake: a beat moves when valid & ready are both high at a rising clock
// edge. A valid source holds valid and data steady until the beat moves.
// in_ready is a flop output, so an upstream stall never sees a combinational
// path from out_ready or flush.
//
// Storage: the main register M drives out_*. The skid register S catches the
// beat that was accepted while M was stalled. The FSM state is encoded as
// the entry count, so the occupancy output also exposes the state for
// debug: EMPTY=0, ONE=1, FULL=2.
//
// Optional feature (macro PIPE_STAGE_STATS_EN): saturating stall_cycles and
// flush_drops counters. Flush does not clear them; only reset does.
module pipe_stage_skid #(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] RESET_DATA = '0,
    parameter int                CNT_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_drops
`endif
);

    // The state value equals the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] skid_data_q;
    logic              in_ready_q;

    logic              in_fire;
    logic              out_fire;
    logic              main_load_in;
    logic              main_load_skid;
    logic              skid_load;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign occupancy = state_q;

    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and register-load decode; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        skid_load      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d      = ONE;
                    main_load_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_load_in = 1'b1;
                end else if (in_fire) begin
                    state_d   = FULL;
                    skid_load = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    state_d        = ONE;
                    main_load_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // A flushed beat is consumed but discarded; data registers keep
        // their old contents, only the valid state is killed.
        if (flush) begin
            state_d        = EMPTY;
            main_load_in   = 1'b0;
            main_load_skid = 1'b0;
            skid_load      = 1'b0;
        end
    end

    // Upstream ready is registered: low exactly when the skid entry is held.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != FULL);
        end
    end

    // Main payload register: loads from upstream or from the skid entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            main_data_q <= RESET_DATA;
        end else if (main_load_in) begin
            main_data_q <= in_data;
        end else if (main_load_skid) begin
            main_data_q <= skid_data_q;
        end
    end

    // Skid payload register: catches the beat accepted during a stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            skid_data_q <= RESET_DATA;
        end else if (skid_load) begin
            skid_data_q <= in_data;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [2:0]     drop_count;
    logic [CNT_W:0] drop_sum;

    // Entries lost to a flush: held entries not delivered this cycle plus
    // any beat accepted from upstream in the same cycle.
    always_comb begin
        drop_count = {1'b0, occupancy} - {2'b00, out_fire} + {2'b00, in_fire};
        drop_sum   = {1'b0, flush_drops} + {{(CNT_W-2){1'b0}}, drop_count};
    end

    // Stall counter: one per cycle the output is held back, saturating.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    // Flush drop counter: accumulates discarded entries, saturating.
    always_ff @(posedge clock) begin
        if (reset) begin
            flush_drops <= '0;
        end else if (flush) begin
            if (drop_sum[CNT_W]) begin
                flush_drops <= '1;
            end else begin
                flush_drops <= drop_sum[CNT_W-1:0];
            end
        end
    end
`endif

endmodule
